logic_sweep_checker: RTL
========================

LOGIC_SWEEP_CHECKER -- requirements
Module: logic_sweep_checker

Interface
REQ-001 The block SHALL have parameter TRUTH_TABLE, default 4'b0111, expected r for each input vector, indexed by {a,b} (NAND).
REQ-002 The block SHALL have parameter SETTLE_CYCLES, default 1, cycles each vector is held before r is sampled; legal range 1..15.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 The block SHALL have port start, input, 1, request to begin a sweep.
REQ-006 The block SHALL have port a, output, 1, stimulus bit to the gate under test (vector MSB).
REQ-007 The block SHALL have port b, output, 1, stimulus bit to the gate under test (vector LSB).
REQ-008 The block SHALL have port r, input, 1, result returned by the gate under test.
REQ-009 The block SHALL have port busy, output, 1, high while a sweep is in progress.
REQ-010 The block SHALL have port done, output, 1, high while a sweep has completed and results are valid.
REQ-011 The block SHALL have port pass, output, 1, high in DONE only when no mismatch was recorded.
REQ-012 The block SHALL have port err_count, output, 3, number of mismatching vectors in the last sweep (0..4).
REQ-013 The block SHALL have port err_mask, output, 4, bit i set when vector i mismatched.

Function
REQ-014 The FSM SHALL have states IDLE, DRIVE, SAMPLE and DONE.
REQ-015 In IDLE or DONE, start=1 SHALL clear err_count and err_mask, set vector to 0 and enter DRIVE on the next cycle.
REQ-016 start SHALL be ignored while busy (DRIVE or SAMPLE).
REQ-017 In DRIVE and SAMPLE, {a,b} SHALL equal the current vector; in IDLE and DONE, a=0 and b=0.
REQ-018 DRIVE SHALL last exactly SETTLE_CYCLES cycles, counted by a 4-bit counter reloaded on entry, then go to SAMPLE.
REQ-019 SAMPLE SHALL last one cycle; r SHALL be compared with TRUTH_TABLE[vector]; on mismatch err_count increments and err_mask[vector] sets.
REQ-020 After SAMPLE, vector 3 SHALL go to DONE; otherwise vector increments and the FSM returns to DRIVE.
REQ-021 busy SHALL be 1 exactly in DRIVE and SAMPLE; done SHALL be 1 exactly in DONE.
REQ-022 pass SHALL equal (err_count==0) in DONE and 0 in all other states.
REQ-023 done SHALL first assert 1+4*(SETTLE_CYCLES+1) cycles after the cycle in which start is accepted (9 cycles at default).
REQ-024 err_count, err_mask and pass SHALL hold in DONE until the next accepted start or reset.
REQ-025 err_count SHALL not exceed 4; no wrap is possible.

Reset
REQ-026 reset=1 at a clock edge SHALL force IDLE, vector=0, counter=0, and a, b, busy, done, pass, err_count, err_mask all 0.
REQ-027 reset SHALL take priority over start and over any in-flight sweep; a sweep interrupted by reset is discarded.
REQ-028 start sampled together with reset SHALL be ignored.

Configuration
REQ-029 Macro SWEEP_STOP_ON_ERROR_EN: when defined, the first mismatch in SAMPLE SHALL send the FSM straight to DONE with pass=0, and remaining vectors SHALL not be driven.
REQ-030 Without SWEEP_STOP_ON_ERROR_EN, all four vectors SHALL always be swept regardless of mismatches.

Verification
REQ-031 Correct NAND on r, default parameters, start pulse at cycle 0 -> done=1 at cycle 9, pass=1, err_count=0, err_mask=4'b0000.
REQ-032 AND gate on r (r=a&b) -> err_count=4, err_mask=4'b1111, pass=0 in DONE.
REQ-033 r stuck at 1 -> only vector 3 mismatches: err_count=1, err_mask=4'b1000, pass=0.
REQ-034 SWEEP_STOP_ON_ERROR_EN defined, AND gate on r, start at cycle 0 -> done=1 at cycle 3, err_count=1, err_mask=4'b0001, and {a,b} never reaches 2'b01.
REQ-035 reset=1 at cycle 4 of a sweep -> at cycle 5 busy=0, done=0, a=b=0, err_count=0; a new start at cycle 6 completes normally with done at cycle 15.
REQ-036 SETTLE_CYCLES=3, start pulsed again at cycle 5 mid-sweep -> the second pulse is ignored; done at cycle 17 with a correct NAND.

Source files
------------

// File: rtl/logic_sweep_checker.sv
// logic_sweep_checker
//   Exhaustively sweeps the four input vectors {a,b} of a 2-input gate under
//   test. Each vector is held for SETTLE_CYCLES cycles, then the returned bit r
//   is compared with TRUTH_TABLE[{a,b}]. Mismatches are counted and flagged
//   per vector.
//
// Parameters
//   TRUTH_TABLE   expected r, indexed by {a,b} (default NAND = 4'b0111)
//   SETTLE_CYCLES cycles each vector is held before sampling, 1..15
//
// Ports
//   clk        single clock, rising edge
//   reset      synchronous, active high
//   start      begin a sweep (ignored while busy, or together with reset)
//   a, b       stimulus to the gate (a = vector MSB); 0 when not sweeping
//   r          gate result
//   busy       sweep in progress (DRIVE/SAMPLE)
//   done       sweep finished, results valid
//   pass       done with no mismatches
//   err_count  number of mismatching vectors (0..4)
//   err_mask   bit i set when vector i mismatched
//
// Configuration
//   SWEEP_STOP_ON_ERROR_EN  when defined, the first mismatch ends the sweep.
module logic_sweep_checker #(
  parameter logic [3:0] TRUTH_TABLE   = 4'b0111,
  parameter int         SETTLE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic       a,
  output logic       b,
  input  logic       r,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count,
  output logic [3:0] err_mask
);

  // Counter is loaded with SETTLE_CYCLES-1 so DRIVE lasts exactly
  // SETTLE_CYCLES cycles (it leaves DRIVE on the cycle it reads zero).
  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;

  state_t     state, state_nxt;
  logic [1:0] vec;
  logic [3:0] cnt;
  logic       mismatch;

  assign mismatch = (r != TRUTH_TABLE[vec]);

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE, DONE: if (start) state_nxt = DRIVE;
      DRIVE:      if (cnt == 4'd0) state_nxt = SAMPLE;
      SAMPLE: begin
`ifdef SWEEP_STOP_ON_ERROR_EN
        if (mismatch || vec == 2'd3) state_nxt = DONE;
        else                         state_nxt = DRIVE;
`else
        if (vec == 2'd3) state_nxt = DONE;
        else             state_nxt = DRIVE;
`endif
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Vector, settle counter and error bookkeeping
  always_ff @(posedge clk) begin
    if (reset) begin
      vec       <= 2'd0;
      cnt       <= 4'd0;
      err_count <= 3'd0;
      err_mask  <= 4'd0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            vec       <= 2'd0;
            cnt       <= SETTLE_LOAD;
            err_count <= 3'd0;
            err_mask  <= 4'd0;
          end
        end
        DRIVE: begin
          if (cnt != 4'd0) cnt <= cnt - 4'd1;
        end
        SAMPLE: begin
          if (mismatch) begin
            // At most four samples per sweep, so the count cannot wrap.
            err_count     <= err_count + 3'd1;
            err_mask[vec] <= 1'b1;
          end
          if (state_nxt == DRIVE) begin
            vec <= vec + 2'd1;
            cnt <= SETTLE_LOAD;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs
  always_comb begin
    busy = (state == DRIVE) || (state == SAMPLE);
    done = (state == DONE);
    pass = done && (err_count == 3'd0);
    a    = busy ? vec[1] : 1'b0;
    b    = busy ? vec[0] : 1'b0;
  end

endmodule
